sm83_irq_ctrl: RTL and testbench
================================

SM83_IRQ_CTRL -- requirements
Module: sm83_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 5, number of interrupt channels; legal range 1..8.
REQ-002 Parameter VEC_BASE, default 16'h0040, vector address of channel 0.
REQ-003 Parameter VEC_STRIDE, default 8, vector address spacing between channels.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 irq_req  input  NUM_IRQ  per-channel request; sampled high in a cycle sets the matching IF bit.
REQ-007 ie_wen / if_wen  input  1 each  register write strobes.
REQ-008 wr_data  input  8  write data for IE/IF.
REQ-009 ie_q / if_q  output  8  register read values.
REQ-010 ei / di / reti  input  1 each  single-cycle instruction strobes from control.
REQ-011 instr_boundary  input  1  pulse when control fetches the next opcode.
REQ-012 m_tick  input  1  pulse marking the end of one M-cycle.
REQ-013 disp_req  output  1  dispatch requested at the next instruction boundary.
REQ-014 disp_ack  input  1  control accepts dispatch and starts the sequence.
REQ-015 disp_phase  output  3  current dispatch M-cycle, 0..4.
REQ-016 disp_busy / disp_done  output  1 each  sequence active / single-cycle completion pulse.
REQ-017 vector  output  16  jump target, valid in phase 4.
REQ-018 ime  output  1  master enable.
REQ-019 wake  output  1  halt-exit request.

Function
REQ-020 pend = IE[NUM_IRQ-1:0] & IF[NUM_IRQ-1:0]; the lowest set index has highest priority.
REQ-021 IE is a full 8-bit register; IF stores NUM_IRQ bits; if_q bits at index NUM_IRQ and above read 1.
REQ-022 On a same-cycle irq_req and if_wen to one bit, the hardware set wins (bit ends 1).
REQ-023 wake = |pend, combinational, independent of IME.
REQ-024 disp_req = ime & |pend & ~disp_busy, combinational.
REQ-025 States: IDLE, DISPATCH.
REQ-026 IDLE->DISPATCH when disp_ack & disp_req; the IME clear and disp_phase=0 take effect on that edge.
REQ-027 disp_ack while disp_req=0 is ignored.
REQ-028 In DISPATCH, disp_phase increments on each m_tick.
REQ-029 Phases 0-1 are wait cycles; phase 2 is the PC-high push; phase 3 is the PC-low push.
REQ-030 At the m_tick ending phase 2, the winner is re-evaluated from the current pend: that index is latched and its IF bit cleared.
REQ-031 If pend=0 at that point, no IF bit is cleared and vector=16'h0000 (cancelled dispatch).
REQ-032 vector = VEC_BASE + VEC_STRIDE*index, 16-bit arithmetic, wraps modulo 2^16.
REQ-033 At the m_tick ending phase 4: disp_done pulses for 1 cycle, the block returns to IDLE, and disp_phase returns to 0.
REQ-034 EI: a 1-deep pending flag is set; IME goes 1 at the second subsequent instr_boundary, i.e. after the next instruction.
REQ-035 DI clears IME and the pending EI flag on the next edge.
REQ-036 RETI sets IME on the next edge, with no delay.
REQ-037 ei/di/reti arriving in the same cycle: DI wins over the others; RETI wins over EI.
REQ-038 ie_wen/if_wen during DISPATCH take effect immediately and feed the REQ-030 evaluation.
REQ-039 ei/di/reti during DISPATCH are ignored.
REQ-040 disp_busy = 1 throughout DISPATCH.

Reset
REQ-041 While rst_n=0, the following outputs are driven: IE=0, IF=0, ime=0, EI flag=0, state=IDLE, disp_phase=0, disp_busy=0, disp_done=0, vector=0.
REQ-042 Reset asserted mid-DISPATCH aborts the sequence with no disp_done pulse.

Verification
REQ-043 Priority: IE=0x1F, ime=1, irq_req=5'b10100, disp_ack, then 5 m_ticks -> vector=0x0050, disp_done pulses once, IF=0x14->0x10 (IF bit 2 cleared), ime=0.
REQ-044 Cancel: mid phase 2, write IE=0 -> vector=0x0000, IF unchanged, disp_done still pulses.
REQ-045 EI delay: ei, one instr_boundary -> ime=0; second instr_boundary -> ime=1; di then ei in the same cycle -> ime stays 0.
REQ-046 Wake: ime=0, IE=0x04, irq_req[2] -> wake=1, disp_req=0; if_q reads 0xE4 with NUM_IRQ=5.
REQ-047 Collision: if_wen with wr_data=0 in the same cycle as irq_req[0] -> IF bit 0 ends 1.
REQ-048 Params: NUM_IRQ=8, VEC_STRIDE=16, winner index 7 -> vector=0x00B0; rst_n low in phase 3 -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/sm83_irq_ctrl.sv
// rtl/sm83_irq_ctrl.sv - SM83-style interrupt controller: IE/IF registers, IME/EI delay, 5 M-cycle dispatch sequencer
module sm83_irq_ctrl #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               ie_wen,
    input  logic               if_wen,
    input  logic [7:0]         wr_data,
    output logic [7:0]         ie_q,
    output logic [7:0]         if_q,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               instr_boundary,
    input  logic               m_tick,
    output logic               disp_req,
    input  logic               disp_ack,
    output logic [2:0]         disp_phase,
    output logic               disp_busy,
    output logic               disp_done,
    output logic [15:0]        vector,
    output logic               ime,
    output logic               wake
);

    typedef enum logic {S_IDLE, S_DISPATCH} state_t;

    state_t             state;
    logic [7:0]         ie_r;
    logic [NUM_IRQ-1:0] if_r;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] if_clr;
    logic               any_pend;
    logic [2:0]         win_idx;
    logic [15:0]        win_vec;
    logic               latch_win;
    logic               ei_wait1;
    logic               ei_wait2;

    assign pend      = ie_r[NUM_IRQ-1:0] & if_r;
    assign any_pend  = |pend;
    assign wake      = any_pend;
    assign disp_busy = (state == S_DISPATCH);
    assign disp_req  = ime & any_pend & ~disp_busy;
    assign ie_q      = ie_r;

    // IF bits beyond the implemented channels read as 1
    always_comb begin
        if_q = 8'hFF;
        if_q[NUM_IRQ-1:0] = if_r;
    end

    always_comb begin
        win_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) win_idx = 3'(i);
        end
    end

    assign win_vec   = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, win_idx};
    assign latch_win = disp_busy & m_tick & (disp_phase == 3'd2);

    always_comb begin
        if_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if_clr[i] = latch_win & any_pend & (win_idx == 3'(i));
        end
    end

    // Hardware request is ORed last so it beats both software writes and the dispatch clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_r <= 8'h00;
            if_r <= '0;
        end else begin
            if (ie_wen) ie_r <= wr_data;
            if_r <= ((if_wen ? wr_data[NUM_IRQ-1:0] : if_r) & ~if_clr) | irq_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            disp_phase <= 3'd0;
            disp_done  <= 1'b0;
            vector     <= 16'h0000;
            ime        <= 1'b0;
            ei_wait1   <= 1'b0;
            ei_wait2   <= 1'b0;
        end else begin
            disp_done <= 1'b0;
            if (state == S_IDLE) begin
                // EI arms IME only after the instruction following it has completed
                if (instr_boundary) begin
                    if (ei_wait1) begin
                        ei_wait1 <= 1'b0;
                        ei_wait2 <= 1'b1;
                    end
                    if (ei_wait2) begin
                        ei_wait2 <= 1'b0;
                        ime      <= 1'b1;
                    end
                end
                if (di) begin
                    ime      <= 1'b0;
                    ei_wait1 <= 1'b0;
                    ei_wait2 <= 1'b0;
                end else if (reti) begin
                    ime <= 1'b1;
                end else if (ei) begin
                    ei_wait1 <= 1'b1;
                    ei_wait2 <= 1'b0;
                end
                if (disp_ack && disp_req) begin
                    state      <= S_DISPATCH;
                    disp_phase <= 3'd0;
                    ime        <= 1'b0;
                end
            end else if (m_tick) begin
                if (disp_phase == 3'd2) begin
                    vector <= any_pend ? win_vec : 16'h0000;
                end
                if (disp_phase == 3'd4) begin
                    state      <= S_IDLE;
                    disp_phase <= 3'd0;
                    disp_done  <= 1'b1;
                end else begin
                    disp_phase <= disp_phase + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb/tb_sm83_irq_ctrl.sv - randomized and directed bench for sm83_irq_ctrl against a behavioural model
module tb_sm83_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  irq_req = '0;
    logic [7:0]  irq8 = '0;
    logic        ie_wen = 1'b0, if_wen = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        ei = 1'b0, di = 1'b0, reti = 1'b0, instr_boundary = 1'b0, m_tick = 1'b0, disp_ack = 1'b0;

    logic [7:0]  ie_q, if_q, ie_q8, if_q8;
    logic        disp_req, disp_busy, disp_done, ime, wake;
    logic        disp_req8, disp_busy8, disp_done8, ime8, wake8;
    logic [2:0]  disp_phase, disp_phase8;
    logic [15:0] vector, vector8;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state (default-parameter instance)
    logic [7:0]  m_ie;
    logic [4:0]  m_if;
    logic        m_ime, m_busy, m_done;
    int          m_ei_left, m_phase;
    logic [15:0] m_vec;

    always #5 clk = ~clk;

    sm83_irq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .ie_wen(ie_wen), .if_wen(if_wen),
        .wr_data(wr_data), .ie_q(ie_q), .if_q(if_q), .ei(ei), .di(di), .reti(reti),
        .instr_boundary(instr_boundary), .m_tick(m_tick), .disp_req(disp_req),
        .disp_ack(disp_ack), .disp_phase(disp_phase), .disp_busy(disp_busy),
        .disp_done(disp_done), .vector(vector), .ime(ime), .wake(wake)
    );

    sm83_irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(16'h0040), .VEC_STRIDE(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .irq_req(irq8), .ie_wen(ie_wen), .if_wen(if_wen),
        .wr_data(wr_data), .ie_q(ie_q8), .if_q(if_q8), .ei(ei), .di(di), .reti(reti),
        .instr_boundary(instr_boundary), .m_tick(m_tick), .disp_req(disp_req8),
        .disp_ack(disp_ack), .disp_phase(disp_phase8), .disp_busy(disp_busy8),
        .disp_done(disp_done8), .vector(vector8), .ime(ime8), .wake(wake8)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 8'h00; m_if = 5'h00; m_ime = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_ei_left = 0; m_phase = 0; m_vec = 16'h0000;
    endtask

    task automatic check_outputs();
        logic [4:0] pend;
        pend = m_ie[4:0] & m_if;
        check("ie_q", ie_q, m_ie);
        check("if_q", if_q, {3'b111, m_if});
        check("ime", ime, m_ime);
        check("disp_phase", disp_phase, 16'(m_phase));
        check("disp_busy", disp_busy, m_busy);
        check("disp_done", disp_done, m_done);
        check("vector", vector, m_vec);
        check("wake", wake, pend != 0);
        check("disp_req", disp_req, m_ime && pend != 0 && !m_busy);
    endtask

    // next state from the rules, using the inputs currently being driven
    task automatic model_step();
        logic [4:0] pend, nif;
        logic       req, n_ime;
        int         idx, n_left;
        pend   = m_ie[4:0] & m_if;
        req    = m_ime && pend != 0 && !m_busy;
        nif    = if_wen ? wr_data[4:0] : m_if;
        n_ime  = m_ime;
        n_left = m_ei_left;
        m_done = 1'b0;
        if (!m_busy) begin
            if (instr_boundary && m_ei_left > 0) begin
                n_left = m_ei_left - 1;
                if (n_left == 0) n_ime = 1'b1;
            end
            if (di) begin
                n_ime = 1'b0;
                n_left = 0;
            end else if (reti) begin
                n_ime = 1'b1;
            end else if (ei) begin
                n_left = 2;
            end
            if (disp_ack && req) begin
                m_busy = 1'b1;
                m_phase = 0;
                n_ime = 1'b0;
            end
        end else if (m_tick) begin
            if (m_phase == 2) begin
                idx = -1;
                for (int i = 4; i >= 0; i--) if (pend[i]) idx = i;
                if (idx >= 0) begin
                    nif[idx] = 1'b0;
                    m_vec = 16'(16'h0040 + 8 * idx);
                end else begin
                    m_vec = 16'h0000;
                end
            end
            if (m_phase == 4) begin
                m_busy = 1'b0;
                m_phase = 0;
                m_done = 1'b1;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        if (ie_wen) m_ie = wr_data;
        m_if = nif | irq_req;
        m_ime = n_ime;
        m_ei_left = n_left;
    endtask

    task automatic cyc(input logic [4:0] rq, input logic iew, input logic ifw, input logic [7:0] wd,
                       input logic e, input logic d, input logic r, input logic ib,
                       input logic mt, input logic ack);
        @(negedge clk);
        check_outputs();
        irq_req = rq; ie_wen = iew; if_wen = ifw; wr_data = wd;
        ei = e; di = d; reti = r; instr_boundary = ib; m_tick = mt; disp_ack = ack;
        model_step();
    endtask

    task automatic idle();
        cyc(5'd0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        cyc(5'd0, 0, 0, 8'd0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic clear_inputs();
        irq_req = '0; irq8 = '0; ie_wen = 0; if_wen = 0; wr_data = '0;
        ei = 0; di = 0; reti = 0; instr_boundary = 0; m_tick = 0; disp_ack = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // priority: bit 2 beats bit 4
        cyc(5'd0, 1, 0, 8'h1F, 0, 0, 0, 0, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
        cyc(5'b10100, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        check("prio_if_before", if_q, 16'h00F4);
        repeat (5) tick();
        check("prio_vector", vector, 16'h0050);
        check("prio_if_after", if_q, 16'h00F0);
        idle();
        check("prio_done", disp_done, 1'b1);
        check("prio_ime", ime, 1'b0);
        idle();
        check("prio_done_once", disp_done, 1'b0);

        // cancelled dispatch
        do_reset();
        cyc(5'd0, 1, 0, 8'h1F, 0, 0, 0, 0, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
        cyc(5'b00010, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        tick(); tick();
        cyc(5'd0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("cancel_vector", vector, 16'h0000);
        check("cancel_if", if_q, 16'h00E2);
        idle();
        check("cancel_done", disp_done, 1'b1);

        // EI delay and DI+EI collision
        do_reset();
        cyc(5'd0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
        idle();
        check("ei_first_boundary", ime, 1'b0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
        idle();
        check("ei_second_boundary", ime, 1'b1);
        cyc(5'd0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
        idle();
        check("di_ei_ime", ime, 1'b0);

        // wake without IME
        do_reset();
        cyc(5'd0, 1, 0, 8'h04, 0, 0, 0, 0, 0, 0);
        cyc(5'b00100, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        idle();
        check("wake", wake, 1'b1);
        check("wake_disp_req", disp_req, 1'b0);
        check("wake_if_q", if_q, 16'h00E4);

        // same-cycle hardware set vs software clear
        do_reset();
        cyc(5'b00001, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        idle();
        check("collision_if0", if_q[0], 1'b1);

        // wide instance: channel 7 vector, then reset in phase 3
        do_reset();
        cyc(5'd0, 1, 0, 8'h80, 0, 0, 0, 0, 0, 0);
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
        irq8 = 8'h80;
        idle();
        irq8 = 8'h00;
        cyc(5'd0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        idle();
        check("p8_phase", disp_phase8, 16'd3);
        check("p8_vector", vector8, 16'h00B0);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check("p8_rst_ie", ie_q8, 16'h0000);
        check("p8_rst_if", if_q8, 16'h0000);
        check("p8_rst_ime", ime8, 1'b0);
        check("p8_rst_phase", disp_phase8, 16'd0);
        check("p8_rst_busy", disp_busy8, 1'b0);
        check("p8_rst_done", disp_done8, 1'b0);
        check("p8_rst_vector", vector8, 16'h0000);
        check("p8_rst_req", disp_req8, 1'b0);
        check("p8_rst_wake", wake8, 1'b0);
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            cyc(($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, 8'($urandom),
                $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
